// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN (alignment checking) is consumed
// by dmem_arbiter; this package only provides the helper it uses.
package dmem_arb_pkg;

    // Sequencer states: wait for a request, hold the address, return the ack.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Requester indices as carried on grant/port registers.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Cycles the memory address is held before an access completes.
    localparam int DEFAULT_LATENCY = 2;

    // True when a byte address does not point at the start of a 32-bit word.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: purely combinational, no state of its own.
// The owner keeps last_grant and feeds it back so ties alternate.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    // Pick the lone requester, or on a tie the port that did not win last time.
    always_comb begin
        // NOTE: every output gets a value before any branch so no latch is inferred.
        gnt_valid_o = req0_i | req1_i;
        gnt_idx_o   = PORT0;
        if (req0_i && req1_i) begin
            gnt_idx_o = ~last_grant_i;
        end else if (req1_i) begin
            gnt_idx_o = PORT1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the byte-addressed data memory.
// Port 0 is the pipeline MEM stage, port 1 a secondary master (debug/DMA).
// Each transaction: grant in IDLE, hold the address for LATENCY cycles in
// ACCESS (write strobe or read capture on the last one), one-cycle ack in DONE.
// Build macro DMEM_ARB_ALIGN_CHECK_EN: misaligned addresses skip the memory
// access and complete with ack+err; without it err outputs are tied low.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              err0_o,

    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              err1_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o,
    output logic              grant_o
);

    // The counter only ever holds LATENCY-1 down to 0.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic              err_q, err_d;
`endif

    logic              gnt_valid;
    logic              gnt_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              mem_we;

    rr_arb2 u_rr_arb2 (
        .req0_i       (req0_i),
        .req1_i       (req1_i),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx)
    );

    // Route the winning port's request fields toward the latch registers.
    always_comb begin
        sel_we    = we0_i;
        sel_addr  = addr0_i;
        sel_wdata = wdata0_i;
        if (gnt_idx == PORT1) begin
            sel_we    = we1_i;
            sel_addr  = addr1_i;
            sel_wdata = wdata1_i;
        end
    end

    // Next-state and datapath updates for the IDLE/ACCESS/DONE sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        err_d        = err_q;
`endif
        mem_we       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    // Inputs are captured here; later changes on the port are ignored.
                    port_d       = gnt_idx;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    last_grant_d = gnt_idx;
                    grant_d      = gnt_idx;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_ACCESS;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                    err_d        = 1'b0;
                    if (is_misaligned(sel_addr[1:0])) begin
                        // Never touch memory; report the error with zeroed read data.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                        if (gnt_idx == PORT1) begin
                            rdata1_d = '0;
                        end else begin
                            rdata0_d = '0;
                        end
                    end
`endif
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        // The only cycle in which the write strobe is asserted.
                        mem_we = 1'b1;
                    end else if (port_q == PORT1) begin
                        rdata1_d = mem_rdata_i;
                    end else begin
                        rdata0_d = mem_rdata_i;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset forces every output-visible value low.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            port_q       <= PORT0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= PORT1;
            grant_q      <= PORT0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    // Outputs are decoded from registers only, so reset clears them at once.
    always_comb begin
        ack0_o      = (state_q == ST_DONE) && (port_q == PORT0);
        ack1_o      = (state_q == ST_DONE) && (port_q == PORT1);
        busy_o      = (state_q != ST_IDLE);
        grant_o     = grant_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_we_o    = mem_we;
        rdata0_o    = rdata0_q;
        rdata1_o    = rdata1_q;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        err0_o      = ack0_o && err_q;
        err1_o      = ack1_o && err_q;
`else
        err0_o      = 1'b0;
        err1_o      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and a
// transaction-level reference model (round-robin order, fixed latencies,
// word-array memory contents).
module tb_dmem_arbiter;

    localparam int LAT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_i, we0_i, req1_i, we1_i;
    logic [31:0] addr0_i, wdata0_i, addr1_i, wdata1_i;
    logic        ack0_o, ack1_o, err0_o, err1_o;
    logic [31:0] rdata0_o, rdata1_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_we_o, busy_o, grant_o;

    int checks = 0;
    int errors = 0;
    int model_last;
    logic [31:0] ref_mem [0:255];

    // Behavioural memory: unwritten words return a fixed per-index pattern.
    logic [31:0] tb_mem  [0:255];
    bit          written [0:255];
    logic [7:0]  midx;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 2) return 32'h1122_3344;
        return 32'hA500_0000 ^ (32'(idx) * 32'h0001_0101);
    endfunction

    assign midx        = mem_addr_o[9:2];
    assign mem_rdata_i = written[midx] ? tb_mem[midx] : init_word(int'(midx));

    always @(posedge clk_i) begin
        if (mem_we_o) begin
            tb_mem[midx]  <= mem_wdata_o;
            written[midx] <= 1'b1;
        end
    end

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
        .ack0_o(ack0_o), .rdata0_o(rdata0_o), .err0_o(err0_o),
        .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
        .ack1_o(ack1_o), .rdata1_o(rdata1_o), .err1_o(err1_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .grant_o(grant_o)
    );

    // One request from one port, started just after a rising edge with the DUT idle.
    // Cycle 0 is the cycle the request is presented; observations are taken on falling edges.
    task automatic drive_one(input logic port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int drop_at,
                             output int ack_cyc, output int we_n, output int we_cyc,
                             output logic [31:0] we_addr, output logic [31:0] we_data,
                             output logic [31:0] rd, output logic err,
                             output logic other_ack, output logic [31:0] acc_addr);
        ack_cyc = -1; we_n = 0; we_cyc = -1; we_addr = '0; we_data = '0;
        rd = '0; err = 1'b0; other_ack = 1'b0; acc_addr = '0;
        if (port) begin
            req1_i = 1'b1; we1_i = we; addr1_i = addr; wdata1_i = wdata;
        end else begin
            req0_i = 1'b1; we0_i = we; addr0_i = addr; wdata0_i = wdata;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (c == 1) acc_addr = mem_addr_o;
            if (mem_we_o) begin
                we_n++; we_cyc = c; we_addr = mem_addr_o; we_data = mem_wdata_o;
            end
            if (port ? ack0_o : ack1_o) other_ack = 1'b1;
            if (c == drop_at) begin
                if (port) req1_i = 1'b0; else req0_i = 1'b0;
            end
            if (port ? ack1_o : ack0_o) begin
                ack_cyc = c;
                rd  = port ? rdata1_o : rdata0_o;
                err = port ? err1_o : err0_o;
                break;
            end
        end
        req0_i = 1'b0; req1_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        req0_i = 0; we0_i = 0; addr0_i = '0; wdata0_i = '0;
        req1_i = 0; we1_i = 0; addr1_i = '0; wdata1_i = '0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({ack0_o, ack1_o, err0_o, err1_o, mem_we_o, busy_o, grant_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {ack0_o, ack1_o, err0_o, err1_o, mem_we_o, busy_o, grant_o});
        end
        checks++;
        if ({rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected zeros",
                     rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        model_last = 1;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", busy_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_single_read();
        int ack_cyc, we_n, we_cyc;
        logic [31:0] wa, wd, rd, acc;
        logic err, oth;
        drive_one(1'b0, 1'b0, 32'h8, 32'h0, -1, ack_cyc, we_n, we_cyc, wa, wd, rd, err, oth, acc);
        checks++;
        if (ack_cyc !== LAT + 1) begin
            errors++; $display("FAIL read_ack_cycle: got %0d expected %0d", ack_cyc, LAT + 1);
        end
        checks++;
        if (rd !== 32'h1122_3344) begin
            errors++; $display("FAIL read_data: got %h expected 11223344", rd);
        end
        checks++;
        if ({oth, we_n != 0, err} !== 3'b000) begin
            errors++; $display("FAIL read_side_effects: got ack1=%b we_n=%0d err=%b expected 0 0 0", oth, we_n, err);
        end
        checks++;
        if (acc !== 32'h8) begin
            errors++; $display("FAIL read_mem_addr: got %h expected 00000008", acc);
        end
        checks++;
        if (grant_o !== 1'b0) begin
            errors++; $display("FAIL read_grant: got %b expected 0", grant_o);
        end
        model_last = 0;
    endtask

    task automatic test_write_read();
        int ack_cyc, we_n, we_cyc;
        logic [31:0] wa, wd, rd, acc;
        logic err, oth;
        drive_one(1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF, -1, ack_cyc, we_n, we_cyc, wa, wd, rd, err, oth, acc);
        checks++;
        if (we_n !== 1 || we_cyc !== LAT) begin
            errors++; $display("FAIL write_strobe: got count=%0d cycle=%0d expected 1 at %0d", we_n, we_cyc, LAT);
        end
        checks++;
        if (wa !== 32'h4 || wd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_bus: got %h/%h expected 00000004/deadbeef", wa, wd);
        end
        checks++;
        if (ack_cyc !== LAT + 1 || oth !== 1'b0) begin
            errors++; $display("FAIL write_ack: got cycle=%0d ack0=%b expected %0d 0", ack_cyc, oth, LAT + 1);
        end
        checks++;
        if (grant_o !== 1'b1) begin
            errors++; $display("FAIL write_grant: got %b expected 1", grant_o);
        end
        ref_mem[1] = 32'hDEAD_BEEF;
        model_last = 1;
        drive_one(1'b0, 1'b0, 32'h4, 32'h0, -1, ack_cyc, we_n, we_cyc, wa, wd, rd, err, oth, acc);
        checks++;
        if (rd !== ref_mem[1] || ack_cyc !== LAT + 1) begin
            errors++; $display("FAIL readback: got %h at %0d expected %h at %0d", rd, ack_cyc, ref_mem[1], LAT + 1);
        end
        model_last = 0;
    endtask

    task automatic test_contention();
        int exp_port, n, p;
        n = 0;
        exp_port = 1 - model_last;
        req0_i = 1; we0_i = 0; addr0_i = 32'h10;
        req1_i = 1; we1_i = 0; addr1_i = 32'h14;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (ack0_o && ack1_o) begin
                checks++; errors++; $display("FAIL contention_dual_ack: got both acks expected one");
            end
            if (ack0_o || ack1_o) begin
                p = ack1_o ? 1 : 0;
                checks++;
                if (p !== exp_port) begin
                    errors++; $display("FAIL contention_order: got port %0d expected %0d (ack #%0d)", p, exp_port, n);
                end
                checks++;
                if (c !== LAT + 1 + n * (LAT + 2)) begin
                    errors++; $display("FAIL contention_spacing: got cycle %0d expected %0d", c, LAT + 1 + n * (LAT + 2));
                end
                checks++;
                if ((p ? rdata1_o : rdata0_o) !== ref_mem[p ? 5 : 4]) begin
                    errors++; $display("FAIL contention_data: got %h expected %h", p ? rdata1_o : rdata0_o, ref_mem[p ? 5 : 4]);
                end
                model_last = p;
                exp_port = 1 - p;
                n++;
                if (n == 4) begin
                    req0_i = 0; req1_i = 0;
                    break;
                end
            end
        end
        req0_i = 0; req1_i = 0;
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL contention_count: got %0d acks expected 4", n);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_drop();
        int ack_cyc, we_n, we_cyc;
        logic [31:0] wa, wd, rd, acc;
        logic err, oth;
        drive_one(1'b0, 1'b0, 32'h20, 32'h0, 1, ack_cyc, we_n, we_cyc, wa, wd, rd, err, oth, acc);
        checks++;
        if (ack_cyc !== LAT + 1) begin
            errors++; $display("FAIL drop_ack: got cycle %0d expected %0d", ack_cyc, LAT + 1);
        end
        checks++;
        if (rd !== ref_mem[8]) begin
            errors++; $display("FAIL drop_data: got %h expected %h", rd, ref_mem[8]);
        end
        model_last = 0;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || ack0_o !== 1'b0) begin
            errors++; $display("FAIL drop_idle: got busy=%b ack0=%b expected 0 0", busy_o, ack0_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        int acks, ack_cyc, we_n, we_cyc;
        logic [31:0] wa, wd, rd, acc;
        logic err, oth;
        acks = 0;
        req0_i = 1; we0_i = 1; addr0_i = 32'h80; wdata0_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_o);
        end
        #1 rst_i = 1'b0;
        #1;
        checks++;
        if ({ack0_o, ack1_o, err0_o, err1_o, mem_we_o, busy_o, grant_o} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: got %b expected 0000000",
                     {ack0_o, ack1_o, err0_o, err1_o, mem_we_o, busy_o, grant_o});
        end
        checks++;
        if ({rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o} !== 128'b0) begin
            errors++;
            $display("FAIL rstmid_data: got %h %h %h %h expected zeros",
                     rdata0_o, rdata1_o, mem_addr_o, mem_wdata_o);
        end
        req0_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (ack0_o || ack1_o) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", acks);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        model_last = 1;
        drive_one(1'b0, 1'b0, 32'h8, 32'h0, -1, ack_cyc, we_n, we_cyc, wa, wd, rd, err, oth, acc);
        checks++;
        if (ack_cyc !== LAT + 1 || rd !== ref_mem[2]) begin
            errors++; $display("FAIL rstmid_recover: got %h at %0d expected %h at %0d", rd, ack_cyc, ref_mem[2], LAT + 1);
        end
        model_last = 0;
    endtask

    task automatic test_misaligned();
        int ack_cyc, we_n, we_cyc;
        logic [31:0] wa, wd, rd, acc;
        logic err, oth;
        drive_one(1'b0, 1'b1, 32'h6, 32'h5A5A_0F0F, -1, ack_cyc, we_n, we_cyc, wa, wd, rd, err, oth, acc);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        checks++;
        if (ack_cyc !== 1 || err !== 1'b1) begin
            errors++; $display("FAIL misalign_ack_err: got cycle=%0d err=%b expected 1 1", ack_cyc, err);
        end
        checks++;
        if (we_n !== 0 || rd !== 32'h0) begin
            errors++; $display("FAIL misalign_no_access: got we_n=%0d rdata=%h expected 0 00000000", we_n, rd);
        end
        checks++;
        if (mem_rdata_i !== ref_mem[1]) begin
            errors++; $display("FAIL misalign_mem: got %h expected %h", mem_rdata_i, ref_mem[1]);
        end
`else
        checks++;
        if (ack_cyc !== LAT + 1 || err !== 1'b0) begin
            errors++; $display("FAIL misalign_plain_ack: got cycle=%0d err=%b expected %0d 0", ack_cyc, err, LAT + 1);
        end
        checks++;
        if (we_n !== 1 || wa !== 32'h6 || wd !== 32'h5A5A_0F0F) begin
            errors++; $display("FAIL misalign_plain_write: got n=%0d %h/%h expected 1 00000006/5a5a0f0f", we_n, wa, wd);
        end
        ref_mem[1] = 32'h5A5A_0F0F;
`endif
        model_last = 0;
    endtask

    task automatic test_random();
        logic        rwe [2];
        int          rword [2];
        logic [31:0] rdat [2];
        int          exp_q[$];
        int          mask, p, prev_c, n, exp_c;
        for (int it = 0; it < 30; it++) begin
            mask = $urandom_range(1, 3);
            exp_q.delete();
            for (int k = 0; k < 2; k++) begin
                rwe[k]   = 1'($urandom_range(0, 1));
                rword[k] = $urandom_range(0, 15);
                rdat[k]  = $urandom;
            end
            if (mask == 3) begin
                exp_q.push_back(1 - model_last);
                exp_q.push_back(model_last);
            end else begin
                exp_q.push_back(mask == 2 ? 1 : 0);
            end
            if (mask[0]) begin
                req0_i = 1; we0_i = rwe[0]; addr0_i = 32'(rword[0] * 4); wdata0_i = rdat[0];
            end
            if (mask[1]) begin
                req1_i = 1; we1_i = rwe[1]; addr1_i = 32'(rword[1] * 4); wdata1_i = rdat[1];
            end
            n = 0; prev_c = 0;
            for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
                @(negedge clk_i);
                if (ack0_o || ack1_o) begin
                    p = ack1_o ? 1 : 0;
                    exp_c = (n == 0) ? LAT + 1 : prev_c + LAT + 2;
                    checks++;
                    if (p !== exp_q[0] || (ack0_o && ack1_o) || c !== exp_c) begin
                        errors++;
                        $display("FAIL rand_order it%0d: got port %0d cycle %0d expected port %0d cycle %0d",
                                 it, p, c, exp_q[0], exp_c);
                    end
                    checks++;
                    if ((p ? err1_o : err0_o) !== 1'b0) begin
                        errors++; $display("FAIL rand_err it%0d: got 1 expected 0", it);
                    end
                    if (rwe[p]) begin
                        ref_mem[rword[p]] = rdat[p];
                    end else begin
                        checks++;
                        if ((p ? rdata1_o : rdata0_o) !== ref_mem[rword[p]]) begin
                            errors++;
                            $display("FAIL rand_rdata it%0d: got %h expected %h (port %0d word %0d)",
                                     it, p ? rdata1_o : rdata0_o, ref_mem[rword[p]], p, rword[p]);
                        end
                    end
                    model_last = p;
                    void'(exp_q.pop_front());
                    if (p == 1) req1_i = 1'b0; else req0_i = 1'b0;
                    prev_c = c;
                    n++;
                end
            end
            req0_i = 0; req1_i = 0;
            checks++;
            if (exp_q.size() != 0) begin
                errors++; $display("FAIL rand_timeout it%0d: got %0d acks expected %0d", it, n, n + exp_q.size());
            end
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_drop();
        test_reset_mid();
        test_misaligned();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
